// File: rtl/show_pkg.sv
// Shared types for the LED show sequencer: FSM state encoding and playback modes.
package show_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Encoding 3 is a reserved alias that plays back like LOOP.
  typedef enum logic [1:0] {
    MODE_ONCE     = 2'd0,
    MODE_LOOP     = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_LOOP_ALT = 2'd3
  } mode_t;

  // A show is in progress while playing or paused.
  function automatic logic is_busy(input state_t s);
    return (s == ST_RUN) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to one tick every DIV cycles while run is high.
module tick_prescaler #(
  parameter int unsigned DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int unsigned    CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = run && w_last;

  // Cycle counter: cleared on slot change, frozen when not running.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/show_sequencer.sv
// LED show sequencer: steps through pattern slots with per-slot durations,
// supporting one-shot, looping and ping-pong playback with pause and skip.
module show_sequencer
  import show_pkg::*;
#(
  parameter int unsigned LED_W    = 16,
  parameter int unsigned NUM_PAT  = 8,
  parameter int unsigned DUR_W    = 7,
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       en,
  input  logic                       skip,
  input  logic [1:0]                 mode,
  input  logic [NUM_PAT*LED_W-1:0]   pat_led,
  input  logic [NUM_PAT*DUR_W-1:0]   dur,
  output logic [LED_W-1:0]           led,
  output logic [$clog2(NUM_PAT)-1:0] cur_pat,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned      IDX_W    = $clog2(NUM_PAT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PAT - 1);

  state_t           r_state;
  state_t           w_next_state;
  mode_t            r_mode;
  mode_t            w_next_mode;
  logic [IDX_W-1:0] r_cur_pat;
  logic [IDX_W-1:0] w_next_idx;
  logic             r_dir_up;
  logic             w_next_dir;
  logic [DUR_W-1:0] r_slot_cnt;
  logic [DUR_W-1:0] w_dur_k;
  logic [LED_W-1:0] w_pat_k;
  logic [LED_W-1:0] r_led;
  logic             r_busy;
  logic             r_done;
  logic             w_run;
  logic             w_tick;
  logic             w_clr;
  logic             w_slot_end;

  assign w_pat_k = pat_led[int'(r_cur_pat)*LED_W +: LED_W];
  assign w_dur_k = dur[int'(r_cur_pat)*DUR_W +: DUR_W];
  assign w_run   = (r_state == ST_RUN);

  // A zero-length slot ends at once; >= guards against dur shrinking mid-slot.
  assign w_slot_end = w_run &&
                      (skip || (w_dur_k == '0) ||
                       (w_tick && (r_slot_cnt >= w_dur_k - DUR_W'(1))));

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .run  (w_run),
    .tick (w_tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, next slot index/direction and counter clear.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_cur_pat;
    w_next_dir   = r_dir_up;
    w_next_mode  = r_mode;
    w_clr        = 1'b0;
    if (start) begin
      w_next_state = ST_RUN;
      w_next_idx   = '0;
      w_next_dir   = 1'b1;
      w_next_mode  = mode_t'(mode);
      w_clr        = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_RUN: begin
          if (!en) begin
            w_next_state = ST_HOLD;
          end
          if (w_slot_end) begin
            w_clr = 1'b1;
            case (r_mode)
              MODE_ONCE: begin
                if (r_cur_pat == LAST_IDX) begin
                  w_next_state = ST_DONE;
                end else begin
                  w_next_idx = r_cur_pat + IDX_W'(1);
                end
              end
              MODE_PINGPONG: begin
                if (r_dir_up) begin
                  if (r_cur_pat == LAST_IDX) begin
                    w_next_idx = r_cur_pat - IDX_W'(1);
                    w_next_dir = 1'b0;
                  end else begin
                    w_next_idx = r_cur_pat + IDX_W'(1);
                  end
                end else begin
                  if (r_cur_pat == '0) begin
                    w_next_idx = r_cur_pat + IDX_W'(1);
                    w_next_dir = 1'b1;
                  end else begin
                    w_next_idx = r_cur_pat - IDX_W'(1);
                  end
                end
              end
              default: begin
                w_next_idx = (r_cur_pat == LAST_IDX) ? '0 : r_cur_pat + IDX_W'(1);
              end
            endcase
          end
        end
        ST_HOLD: begin
          if (en) begin
            w_next_state = ST_RUN;
          end
        end
        ST_DONE: ;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // Slot index, direction, mode, slot counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_pat  <= '0;
      r_dir_up   <= 1'b1;
      r_mode     <= MODE_ONCE;
      r_slot_cnt <= '0;
      r_led      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_cur_pat <= w_next_idx;
      r_dir_up  <= w_next_dir;
      r_mode    <= w_next_mode;
      if (w_clr) begin
        r_slot_cnt <= '0;
      end else if (w_tick) begin
        r_slot_cnt <= r_slot_cnt + DUR_W'(1);
      end
      r_led  <= (r_state == ST_IDLE) ? '0 : w_pat_k;
      r_busy <= is_busy(w_next_state);
      r_done <= (w_next_state == ST_DONE) && (r_state != ST_DONE);
    end
  end

  assign led     = r_led;
  assign cur_pat = r_cur_pat;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_show_sequencer.sv
// Scoreboard bench for show_sequencer: expected slot segments (index, length)
// are queued as each show is launched and compared as the DUT plays them.
module tb_show_sequencer;

  localparam int unsigned LED_W    = 16;
  localparam int unsigned NUM_PAT  = 3;
  localparam int unsigned DUR_W    = 7;
  localparam int unsigned TICK_DIV = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic                     en;
  logic                     skip;
  logic [1:0]               mode;
  logic [NUM_PAT*LED_W-1:0] pat_led;
  logic [NUM_PAT*DUR_W-1:0] dur;
  logic [LED_W-1:0]         led;
  logic [1:0]               cur_pat;
  logic                     busy;
  logic                     done;

  typedef struct {
    int idx;
    int len;
  } seg_t;

  seg_t             exp_q[$];
  int               n_checks = 0;
  int               n_errors = 0;
  int               done_cnt = 0;
  int               done_base;
  bit               mon_en = 1'b1;
  bit               seg_active = 1'b0;
  int               seg_idx = 0;
  int               seg_len = 0;
  logic [LED_W-1:0] pats [NUM_PAT] = '{16'h000F, 16'h00F0, 16'h0F00};

  show_sequencer #(
    .LED_W    (LED_W),
    .NUM_PAT  (NUM_PAT),
    .DUR_W    (DUR_W),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .en      (en),
    .skip    (skip),
    .mode    (mode),
    .pat_led (pat_led),
    .dur     (dur),
    .led     (led),
    .cur_pat (cur_pat),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_seg(input int idx, input int len);
    seg_t s;
    s.idx = idx;
    s.len = len;
    exp_q.push_back(s);
  endtask

  task automatic close_seg();
    seg_t e;
    check_val("seg_expected", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("seg_idx", 32'(seg_idx), 32'(e.idx));
      check_val("seg_len", 32'(seg_len), 32'(e.len));
    end
  endtask

  // Advance to the next falling edge and run the segment monitor there.
  task automatic step();
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
    if (!mon_en) begin
      seg_active = 1'b0;
    end else if (busy === 1'b1) begin
      if (seg_active && int'(cur_pat) == seg_idx) begin
        seg_len++;
        check_val("led_slot", 32'(led), 32'(pats[seg_idx]));
      end else begin
        if (seg_active) close_seg();
        seg_active = 1'b1;
        seg_idx    = int'(cur_pat);
        seg_len    = 1;
      end
    end else if (seg_active) begin
      close_seg();
      seg_active = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check_val(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_start(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_done_state(input string tag);
    repeat (3) step();
    check_val({tag, "_done_once"}, 32'(done_cnt - done_base), 32'd1);
    check_val({tag, "_led"},       32'(led),     32'h0F00);
    check_val({tag, "_busy"},      32'(busy),    32'd0);
    check_val({tag, "_cur_pat"},   32'(cur_pat), 32'd2);
  endtask

  task automatic stop_and_reset();
    mon_en = 1'b0;
    rst    = 1'b1;
    step();
    rst    = 1'b0;
    mon_en = 1'b1;
    step();
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    en      = 1'b1;
    skip    = 1'b0;
    mode    = 2'd0;
    pat_led = {16'h0F00, 16'h00F0, 16'h000F};
    dur     = {7'd3, 7'd1, 7'd2};
    repeat (3) step();
    rst = 1'b0;
    check_val("rst_led",     32'(led),     32'd0);
    check_val("rst_cur_pat", 32'(cur_pat), 32'd0);
    check_val("rst_busy",    32'(busy),    32'd0);
    check_val("rst_done",    32'(done),    32'd0);

    // Skip while idle is ignored.
    skip = 1'b1;
    step();
    skip = 1'b0;
    step();
    check_val("idle_skip_busy",    32'(busy),    32'd0);
    check_val("idle_skip_cur_pat", 32'(cur_pat), 32'd0);
    check_val("idle_skip_led",     32'(led),     32'd0);

    // ONCE playback.
    done_base = done_cnt;
    push_seg(0, 8); push_seg(1, 4); push_seg(2, 12);
    pulse_start(2'd0);
    wait_drain("once_drain", 100);
    check_done_state("once");

    // PINGPONG, with a mode change mid-show that must be ignored.
    done_base = done_cnt;
    push_seg(0, 8); push_seg(1, 4); push_seg(2, 12);
    push_seg(1, 4); push_seg(0, 8); push_seg(1, 4);
    pulse_start(2'd2);
    repeat (10) step();
    mode = 2'd0;
    wait_drain("pp_drain", 200);
    check_val("pp_no_done", 32'(done_cnt - done_base), 32'd0);
    stop_and_reset();

    // LOOP with a 5-cycle pause in slot 1 and a skip during the pause.
    done_base = done_cnt;
    push_seg(0, 8); push_seg(1, 9); push_seg(2, 12); push_seg(0, 8);
    pulse_start(2'd1);
    repeat (9) step();
    en = 1'b0;
    repeat (2) step();
    check_val("hold_busy",    32'(busy),    32'd1);
    check_val("hold_cur_pat", 32'(cur_pat), 32'd1);
    check_val("hold_led",     32'(led),     32'h00F0);
    skip = 1'b1;
    step();
    skip = 1'b0;
    repeat (2) step();
    en = 1'b1;
    wait_drain("loop_drain", 200);
    check_val("loop_no_done", 32'(done_cnt - done_base), 32'd0);
    stop_and_reset();

    // Skip on the third cycle of slot 0.
    done_base = done_cnt;
    push_seg(0, 3); push_seg(1, 4); push_seg(2, 12);
    pulse_start(2'd0);
    repeat (2) step();
    skip = 1'b1;
    step();
    skip = 1'b0;
    wait_drain("skip3_drain", 100);
    check_done_state("skip3");

    // Skip coincident with the slot-0 ending tick: one advance only.
    done_base = done_cnt;
    push_seg(0, 8); push_seg(1, 4); push_seg(2, 12);
    pulse_start(2'd0);
    repeat (7) step();
    skip = 1'b1;
    step();
    skip = 1'b0;
    wait_drain("skipend_drain", 100);
    check_done_state("skipend");

    // Zero-duration slot 1 shows for a single cycle.
    done_base = done_cnt;
    dur = {7'd3, 7'd0, 7'd2};
    push_seg(0, 8); push_seg(1, 1); push_seg(2, 12);
    pulse_start(2'd0);
    wait_drain("dur0_drain", 100);
    check_done_state("dur0");
    dur = {7'd3, 7'd1, 7'd2};

    // Reset in the middle of slot 2 aborts the show.
    push_seg(0, 8); push_seg(1, 4); push_seg(2, 5);
    pulse_start(2'd0);
    repeat (16) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("midrst_led",     32'(led),     32'd0);
    check_val("midrst_cur_pat", 32'(cur_pat), 32'd0);
    check_val("midrst_busy",    32'(busy),    32'd0);
    check_val("midrst_done",    32'(done),    32'd0);
    check_val("midrst_drain",   32'(exp_q.size()), 32'd0);

    // A fresh ONCE show after the abort.
    done_base = done_cnt;
    push_seg(0, 8); push_seg(1, 4); push_seg(2, 12);
    pulse_start(2'd0);
    wait_drain("after_rst_drain", 100);
    check_done_state("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
